mskaes_128bits_input_loader: RTL and testbench

//  Upstream feeder for the masked round-based AES-128 core. Accepts masked key and plaintext as
//  32-bit shared words over a valid/ready stream, assembles full 128*d-bit sharings, and presents

---
 rtl/mskaes_128bits_input_loader.sv | 145 ++++++++++++++
 tb/tb_mskaes_128bits_input_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mskaes_128bits_input_loader.sv
// Input loader for the masked AES-128 core: gathers 32-bit shared words into full key/plaintext sharings.
// Optional feature macro MSKAES_LOADER_KEY_REUSE_EN adds in_key_reuse to keep the key across transactions.
module mskaes_128bits_input_loader #(
  parameter int d = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [32*d-1:0]      in_data,
  input  logic                 in_abort,
`ifdef MSKAES_LOADER_KEY_REUSE_EN
  input  logic                 in_key_reuse,
`endif
  input  logic                 core_ready,
  output logic                 core_valid,
  output logic [128*d-1:0]     core_sh_plaintext,
  output logic [128*d-1:0]     core_sh_key,
  output logic                 busy
);

  localparam int WW = 32 * d;
  localparam int SW = 128 * d;

  typedef enum logic [1:0] {
    LOAD_KEY = 2'd0,
    LOAD_PT  = 2'd1,
    ISSUE    = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [1:0]      wcnt_r, wcnt_s;
  logic [SW-1:0]   key_r, key_s;
  logic [SW-1:0]   pt_r, pt_s;
  logic            key_loaded_r, key_loaded_s;
  logic            accept_s, fetch_s, keep_key_s, retain_s;

  // keep_key_s: key survives a handoff; retain_s: key survives an abort
`ifdef MSKAES_LOADER_KEY_REUSE_EN
  assign keep_key_s = in_key_reuse & key_loaded_r;
  assign retain_s   = key_loaded_r;
`else
  assign keep_key_s = 1'b0;
  assign retain_s   = 1'b0;
`endif

  // Next-state, word routing and handshake decode
  always_comb begin
    state_s      = state_r;
    wcnt_s       = wcnt_r;
    key_s        = key_r;
    pt_s         = pt_r;
    key_loaded_s = key_loaded_r;
    in_ready     = (state_r != ISSUE) && !in_abort;
    fetch_s      = (state_r == ISSUE) && core_ready;
    accept_s     = in_valid && in_ready;
    // An abort loses to a handoff that the core has already accepted
    if (in_abort && !fetch_s) begin
      wcnt_s = 2'd0;
      pt_s   = {SW{1'b0}};
      if (retain_s) begin
        state_s = LOAD_PT;
      end else begin
        key_s        = {SW{1'b0}};
        key_loaded_s = 1'b0;
        state_s      = LOAD_KEY;
      end
    end else begin
      case (state_r)
        LOAD_KEY: begin
          if (accept_s) begin
            key_s[int'(wcnt_r)*WW +: WW] = in_data;
            wcnt_s = wcnt_r + 2'd1;
            if (wcnt_r == 2'd3) begin
              key_loaded_s = 1'b1;
              state_s      = LOAD_PT;
            end else begin
              state_s = LOAD_KEY;
            end
          end else begin
            state_s = LOAD_KEY;
          end
        end
        LOAD_PT: begin
          if (accept_s) begin
            pt_s[int'(wcnt_r)*WW +: WW] = in_data;
            wcnt_s = wcnt_r + 2'd1;
            if (wcnt_r == 2'd3) begin
              state_s = ISSUE;
            end else begin
              state_s = LOAD_PT;
            end
          end else begin
            state_s = LOAD_PT;
          end
        end
        ISSUE: begin
          if (fetch_s) begin
            pt_s = {SW{1'b0}};
            if (keep_key_s) begin
              state_s = LOAD_PT;
            end else begin
              key_s        = {SW{1'b0}};
              key_loaded_s = 1'b0;
              state_s      = LOAD_KEY;
            end
          end else begin
            state_s = ISSUE;
          end
        end
        default: begin
          state_s      = LOAD_KEY;
          wcnt_s       = 2'd0;
          key_s        = {SW{1'b0}};
          pt_s         = {SW{1'b0}};
          key_loaded_s = 1'b0;
        end
      endcase
    end
  end

  // State and share registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r      <= LOAD_KEY;
      wcnt_r       <= 2'd0;
      key_r        <= {SW{1'b0}};
      pt_r         <= {SW{1'b0}};
      key_loaded_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      wcnt_r       <= wcnt_s;
      key_r        <= key_s;
      pt_r         <= pt_s;
      key_loaded_r <= key_loaded_s;
    end
  end

  // Core-facing outputs come straight from registers, gated to zero outside ISSUE
  assign core_valid        = (state_r == ISSUE);
  assign core_sh_key       = core_valid ? key_r : {SW{1'b0}};
  assign core_sh_plaintext = core_valid ? pt_r : {SW{1'b0}};
  assign busy              = (state_r != LOAD_KEY) || (wcnt_r != 2'd0);

endmodule

// File: tb/tb_mskaes_128bits_input_loader.sv
// Self-checking bench for mskaes_128bits_input_loader: random sharings checked against a sharing-level model.
module tb_mskaes_128bits_input_loader;

  localparam int D  = 2;
  localparam int WW = 32 * D;
  localparam int SW = 128 * D;
`ifdef MSKAES_LOADER_KEY_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nrst, in_valid, in_abort, core_ready;
  logic [WW-1:0] in_data;
  logic          in_ready, core_valid, busy;
  logic [SW-1:0] core_sh_plaintext, core_sh_key;
`ifdef MSKAES_LOADER_KEY_REUSE_EN
  logic          in_key_reuse;
`endif

  int checks = 0;
  int errors = 0;
  bit m_key_held = 1'b0;          // model: key retained, next transaction is plaintext only
  logic [SW-1:0] f_ks, f_ps;      // FIPS sharings reused by the gapped test

  mskaes_128bits_input_loader #(.d(D)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_abort(in_abort),
`ifdef MSKAES_LOADER_KEY_REUSE_EN
    .in_key_reuse(in_key_reuse),
`endif
    .core_ready(core_ready), .core_valid(core_valid), .core_sh_plaintext(core_sh_plaintext),
    .core_sh_key(core_sh_key), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Random D-share sharing: shares 1..D-1 random, share 0 completes the XOR
  function automatic logic [SW-1:0] share(input logic [127:0] x);
    logic [SW-1:0] s;
    logic acc, b;
    for (int i = 0; i < 128; i++) begin
      acc = x[i];
      for (int j = 1; j < D; j++) begin
        b = 1'($urandom_range(0, 1));
        s[i*D+j] = b;
        acc = acc ^ b;
      end
      s[i*D] = acc;
    end
    return s;
  endfunction

  function automatic logic [127:0] unshare(input logic [SW-1:0] s);
    logic [127:0] x;
    for (int i = 0; i < 128; i++) x[i] = ^s[i*D +: D];
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends words first..last-1 (0..3 key, 4..7 plaintext), optional idle cycle between words
  task automatic load_words(input logic [SW-1:0] ksh, input logic [SW-1:0] psh,
                            input int first, input int last, input bit gap);
    for (int w = first; w < last; w++) begin
      in_valid = 1'b1;
      in_data  = (w < 4) ? ksh[w*WW +: WW] : psh[(w-4)*WW +: WW];
      #1;
      checks++;
      if (in_ready !== 1'b1 || core_valid !== 1'b0) begin
        errors++;
        $display("FAIL load_handshake w=%0d in_ready=%b core_valid=%b want 1/0", w, in_ready, core_valid);
      end
      tick();
      if (gap && w != last - 1) begin
        in_valid = 1'b0;
        in_data  = WW'(rand128());
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  // Expects ISSUE with the given sharings, then lets the core fetch once
  task automatic issue_and_fetch(input logic [SW-1:0] ksh, input logic [SW-1:0] psh, input bit busy_after);
    checks++;
    if (core_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL issue_flags core_valid=%b in_ready=%b busy=%b want 1/0/1", core_valid, in_ready, busy);
    end
    checks++;
    if (core_sh_key !== ksh) begin
      errors++;
      $display("FAIL issue_key got %h want %h", core_sh_key, ksh);
    end
    checks++;
    if (core_sh_plaintext !== psh) begin
      errors++;
      $display("FAIL issue_pt got %h want %h", core_sh_plaintext, psh);
    end
    core_ready = 1'b1;
    tick();
    checks++;
    if (core_valid !== 1'b0 || in_ready !== 1'b1 || busy !== busy_after) begin
      errors++;
      $display("FAIL post_fetch_flags core_valid=%b in_ready=%b busy=%b want 0/1/%b", core_valid, in_ready, busy, busy_after);
    end
    checks++;
    if (core_sh_key !== {SW{1'b0}} || core_sh_plaintext !== {SW{1'b0}}) begin
      errors++;
      $display("FAIL post_fetch_zero key=%h pt=%h want 0", core_sh_key, core_sh_plaintext);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_valid = 1'b0; in_abort = 1'b0; core_ready = 1'b0; in_data = {WW{1'b0}};
    tick(); tick();
    nrst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || core_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags in_ready=%b core_valid=%b busy=%b want 1/0/0", in_ready, core_valid, busy);
    end
    checks++;
    if (core_sh_key !== {SW{1'b0}} || core_sh_plaintext !== {SW{1'b0}}) begin
      errors++;
      $display("FAIL reset_outputs key=%h pt=%h want 0", core_sh_key, core_sh_plaintext);
    end
  endtask

  task automatic test_fips();
    logic [127:0] key, pt;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    pt  = 128'h00112233445566778899aabbccddeeff;
    f_ks = share(key);
    f_ps = share(pt);
    core_ready = 1'b1;
    load_words(f_ks, f_ps, 0, 8, 1'b0);
    checks++;
    if (unshare(core_sh_key) !== key || unshare(core_sh_plaintext) !== pt) begin
      errors++;
      $display("FAIL fips_unshare key=%h pt=%h want %h %h", unshare(core_sh_key), unshare(core_sh_plaintext), key, pt);
    end
    issue_and_fetch(f_ks, f_ps, 1'b0);
  endtask

  task automatic test_stall();
    logic [SW-1:0] ks, ps;
    ks = share(rand128());
    ps = share(rand128());
    core_ready = 1'b0;
    load_words(ks, ps, 0, 8, 1'b0);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = WW'(rand128());
      #1;
      checks++;
      if (core_valid !== 1'b1 || in_ready !== 1'b0 || core_sh_key !== ks || core_sh_plaintext !== ps) begin
        errors++;
        $display("FAIL stall_hold c=%0d core_valid=%b in_ready=%b key=%h pt=%h", c, core_valid, in_ready, core_sh_key, core_sh_plaintext);
      end
      tick();
    end
    in_valid = 1'b0;
    issue_and_fetch(ks, ps, 1'b0);
    tick();
    checks++;
    if (core_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_single_fetch core_valid=%b want 0", core_valid);
    end
  endtask

  task automatic test_gap();
    core_ready = 1'b1;
    load_words(f_ks, f_ps, 0, 8, 1'b1);
    issue_and_fetch(f_ks, f_ps, 1'b0);
  endtask

  task automatic test_abort();
    logic [SW-1:0] ks, ps, k2, p2;
    ks = share(rand128());
    ps = share(rand128());
    k2 = share(rand128());
    p2 = share(rand128());
    core_ready = 1'b1;
    load_words(ks, ps, 0, 5, 1'b0);
    in_valid = 1'b1;
    in_data  = WW'(rand128());
    in_abort = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_ready got %b want 0", in_ready);
    end
    tick();
    in_abort = 1'b0;
    in_valid = 1'b0;
    if (REUSE) m_key_held = 1'b1;
    checks++;
    if (busy !== m_key_held || core_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_state busy=%b core_valid=%b want %b/0", busy, core_valid, m_key_held);
    end
    load_words(k2, p2, m_key_held ? 4 : 0, 8, 1'b0);
    issue_and_fetch(m_key_held ? ks : k2, p2, 1'b0);
    m_key_held = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] ks, ps;
    ks = share(rand128());
    ps = share(rand128());
    core_ready = 1'b1;
    load_words(ks, ps, 0, 6, 1'b0);
    nrst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || core_valid !== 1'b0 || busy !== 1'b0 ||
        core_sh_key !== {SW{1'b0}} || core_sh_plaintext !== {SW{1'b0}}) begin
      errors++;
      $display("FAIL midreset_outputs in_ready=%b core_valid=%b busy=%b", in_ready, core_valid, busy);
    end
    nrst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (core_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_no_issue c=%0d core_valid=%b want 0", c, core_valid);
      end
    end
    ks = share(rand128());
    ps = share(rand128());
    load_words(ks, ps, 0, 8, 1'b0);
    issue_and_fetch(ks, ps, 1'b0);
  endtask

`ifdef MSKAES_LOADER_KEY_REUSE_EN
  task automatic test_key_reuse();
    logic [SW-1:0] ks, ps, p2, k3, p3;
    ks = share(rand128());
    ps = share(rand128());
    p2 = share(rand128());
    k3 = share(rand128());
    p3 = share(rand128());
    core_ready   = 1'b1;
    in_key_reuse = 1'b1;
    load_words(ks, ps, 0, 8, 1'b0);
    issue_and_fetch(ks, ps, 1'b1);
    load_words(ks, p2, 4, 8, 1'b0);
    in_key_reuse = 1'b0;
    issue_and_fetch(ks, p2, 1'b0);
    load_words(k3, p3, 0, 4, 1'b0);
    checks++;
    if (core_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reuse_cleared core_valid=%b busy=%b want 0/1", core_valid, busy);
    end
    load_words(k3, p3, 4, 8, 1'b0);
    issue_and_fetch(k3, p3, 1'b0);
  endtask
`endif

  initial begin
`ifdef MSKAES_LOADER_KEY_REUSE_EN
    in_key_reuse = 1'b0;
`endif
    test_reset();
    test_fips();
    test_stall();
    test_gap();
    test_abort();
    test_reset_mid();
`ifdef MSKAES_LOADER_KEY_REUSE_EN
    test_key_reuse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
